mem_replay_sched: RTL and testbench
===================================

MEM_REPLAY_SCHED -- requirements
Module: mem_replay_sched

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 19, the memory burst-address width.
REQ-002 SHALL have parameter MEM_ADDR_LOW, default 0, the first burst address of the replay region.
REQ-003 SHALL have parameter MEM_ADDR_HIGH, default 2**MEM_ADDR_WIDTH-1, the last usable burst address of the replay region.
REQ-004 SHALL have parameter CNT_WIDTH, default 32, the width of the loop counters.
REQ-005 SHALL have ports as follows; reset is rst, synchronous, active-high; clock is clk.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- sw_rst  in  1  software reset, same effect as rst.
- cal_done  in  1  memory calibration complete.
- start_load  in  1  pulse: begin a new capture load.
- start_replay  in  1  pulse: begin replay.
- stop  in  1  pulse: abort the current phase.
- replay_count  in  CNT_WIDTH  number of passes; 0 = infinite.
- wr_req  in  1  writer has one burst ready.
- wr_grant  out  1  writer may issue its burst this cycle.
- wr_addr  out  MEM_ADDR_WIDTH  burst address for the granted write.
- rd_req  in  1  reader can accept one burst.
- rd_grant  out  1  reader may issue its burst this cycle.
- rd_addr  out  MEM_ADDR_WIDTH  burst address for the granted read.
- state  out  2  current phase.
- load_words  out  MEM_ADDR_WIDTH+1  number of bursts loaded.
- loops_done  out  CNT_WIDTH  completed replay passes.
- replay_done  out  1  one-cycle pulse at finite replay end.
- overflow  out  1  sticky: load exceeded the region.

Function
REQ-006 SHALL implement three states: IDLE=0, LOAD=1, REPLAY=2; encoding 3 SHALL return to IDLE on the next cycle.
REQ-007 SHALL apply command priority stop > start_load > start_replay within a single cycle.
REQ-008 IDLE: start_load SHALL clear load_words, overflow, and loops_done, set wr_addr=MEM_ADDR_LOW, and enter LOAD next cycle.
REQ-009 IDLE: start_replay with load_words!=0 SHALL clear loops_done, set rd_addr=MEM_ADDR_LOW, and enter REPLAY; with load_words==0 the block SHALL stay in IDLE.
REQ-010 wr_grant SHALL be combinational: wr_req & cal_done & (state==LOAD) & !overflow & !stop.
REQ-011 On each wr_grant, wr_addr and load_words SHALL each increment by 1 at the next clock edge.
REQ-012 A wr_grant while wr_addr==MEM_ADDR_HIGH SHALL be honoured; the block SHALL then set overflow, hold wr_addr, and suppress further wr_grant until the next start_load.
REQ-013 LOAD: start_replay SHALL enter REPLAY if load_words!=0 (including a grant in the same cycle), else IDLE; stop SHALL enter IDLE with load_words retained.
REQ-014 rd_grant SHALL be combinational: rd_req & cal_done & (state==REPLAY) & !stop.
REQ-015 On rd_grant with rd_addr != MEM_ADDR_LOW+load_words-1, rd_addr SHALL increment by 1.
REQ-016 On rd_grant with rd_addr == MEM_ADDR_LOW+load_words-1:
- rd_addr SHALL wrap to MEM_ADDR_LOW and loops_done SHALL increment.
- If replay_count!=0 and loops_done+1==replay_count, the block SHALL enter IDLE and pulse replay_done for 1 cycle.
REQ-017 With replay_count==0, REPLAY SHALL continue until stop; loops_done SHALL wrap modulo 2**CNT_WIDTH.
REQ-018 stop in REPLAY SHALL enter IDLE next cycle with no replay_done pulse; loops_done and load_words SHALL be retained.
REQ-019 start_load and start_replay received in REPLAY SHALL be ignored.
REQ-020 cal_done low SHALL only block grants; state and counters SHALL hold.
REQ-021 wr_grant and rd_grant SHALL never be high in the same cycle.
REQ-022 replay_count SHALL be sampled on every wrap; changing it mid-replay takes effect at the next wrap.

Reset
REQ-023 rst or sw_rst SHALL produce, next cycle: state=IDLE, wr_addr=rd_addr=MEM_ADDR_LOW, load_words=0, loops_done=0, overflow=0, replay_done=0, wr_grant=rd_grant=0.
REQ-024 Reset mid-LOAD or mid-REPLAY SHALL abort the phase with no replay_done pulse and discard the loaded length.

Verification
REQ-025 start_load, 5 wr_req grants, start_replay, replay_count=2, rd_req held high -> rd_addr 0..4,0..4; replay_done pulses on the 10th grant; state=IDLE; loops_done=2.
REQ-026 MEM_ADDR_WIDTH=3 (HIGH=7), continuous wr_req -> 8 grants (addr 0..7), overflow=1, no further wr_grant, load_words=8.
REQ-027 start_replay in IDLE after reset (load_words=0) -> state stays IDLE, no rd_grant.
REQ-028 replay_count=0, 3 loaded bursts, 7 rd grants, then stop asserted with rd_req -> no rd_grant that cycle, IDLE, loops_done=2, replay_done never pulses.
REQ-029 cal_done low during LOAD with wr_req high -> no grants, wr_addr held; cal_done high -> grants resume from the held address.
REQ-030 sw_rst mid-REPLAY at rd_addr=3 -> next cycle IDLE, all counters 0, no replay_done pulse.

Source files
------------

// File: rtl/mem_replay_sched.sv
// mem_replay_sched: sequences a capture load into a linear memory region and then
// replays that region a programmable number of times (or forever).
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   sw_rst             software reset, same effect as rst
//   cal_done           memory calibration done; low only blocks grants
//   start_load         pulse: begin a new capture load
//   start_replay       pulse: begin replay of the loaded bursts
//   stop               pulse: abort the current phase
//   replay_count       number of passes, 0 = infinite (sampled at each wrap)
//   wr_req/wr_grant    writer handshake; wr_addr is the granted burst address
//   rd_req/rd_grant    reader handshake; rd_addr is the granted burst address
//   state              0 IDLE, 1 LOAD, 2 REPLAY
//   load_words         bursts captured by the last load
//   loops_done         completed replay passes
//   replay_done        one-cycle pulse when a finite replay completes
//   overflow           sticky: load ran past MEM_ADDR_HIGH
module mem_replay_sched #(
  parameter int                        MEM_ADDR_WIDTH = 19,
  parameter logic [MEM_ADDR_WIDTH-1:0] MEM_ADDR_LOW   = '0,
  parameter logic [MEM_ADDR_WIDTH-1:0] MEM_ADDR_HIGH  = {MEM_ADDR_WIDTH{1'b1}},
  parameter int                        CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sw_rst,
  input  logic                      cal_done,
  input  logic                      start_load,
  input  logic                      start_replay,
  input  logic                      stop,
  input  logic [CNT_WIDTH-1:0]      replay_count,
  input  logic                      wr_req,
  output logic                      wr_grant,
  output logic [MEM_ADDR_WIDTH-1:0] wr_addr,
  input  logic                      rd_req,
  output logic                      rd_grant,
  output logic [MEM_ADDR_WIDTH-1:0] rd_addr,
  output logic [1:0]                state,
  output logic [MEM_ADDR_WIDTH:0]   load_words,
  output logic [CNT_WIDTH-1:0]      loops_done,
  output logic                      replay_done,
  output logic                      overflow
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, REPLAY = 2'd2} state_t;

  state_t                    state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [MEM_ADDR_WIDTH:0]   words_q, words_d, last_addr;
  logic [CNT_WIDTH-1:0]      loops_q, loops_d, loops_inc;
  logic                      ovf_q, ovf_d, done_q, done_d;

  assign wr_grant = wr_req & cal_done & (state_q == LOAD) & ~ovf_q & ~stop;
  assign rd_grant = rd_req & cal_done & (state_q == REPLAY) & ~stop;

  // Last loaded address, computed one bit wider so a full region cannot alias.
  assign last_addr = {1'b0, MEM_ADDR_LOW} + words_q - 1'b1;
  assign loops_inc = loops_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    words_d   = words_q;
    loops_d   = loops_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    // A grant at MEM_ADDR_HIGH is still honoured; the address then parks there.
    if (wr_grant) begin
      words_d = words_q + 1'b1;
      if (wr_addr_q == MEM_ADDR_HIGH) ovf_d = 1'b1;
      else                            wr_addr_d = wr_addr_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start_load) begin
          words_d   = '0;
          ovf_d     = 1'b0;
          loops_d   = '0;
          wr_addr_d = MEM_ADDR_LOW;
          state_d   = LOAD;
        end else if (start_replay && words_q != '0) begin
          loops_d   = '0;
          rd_addr_d = MEM_ADDR_LOW;
          state_d   = REPLAY;
        end
      end
      LOAD: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start_load) begin
          // Restart the capture from the bottom of the region.
          words_d   = '0;
          ovf_d     = 1'b0;
          loops_d   = '0;
          wr_addr_d = MEM_ADDR_LOW;
        end else if (start_replay) begin
          // words_d already counts a grant taken in this same cycle.
          if (words_d != '0) begin
            loops_d   = '0;
            rd_addr_d = MEM_ADDR_LOW;
            state_d   = REPLAY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      REPLAY: begin
        if (stop) begin
          state_d = IDLE;
        end else if (rd_grant) begin
          if ({1'b0, rd_addr_q} == last_addr) begin
            rd_addr_d = MEM_ADDR_LOW;
            loops_d   = loops_inc;
            if (replay_count != '0 && loops_inc == replay_count) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || sw_rst) begin
      state_q   <= IDLE;
      wr_addr_q <= MEM_ADDR_LOW;
      rd_addr_q <= MEM_ADDR_LOW;
      words_q   <= '0;
      loops_q   <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      words_q   <= words_d;
      loops_q   <= loops_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign wr_addr     = wr_addr_q;
  assign rd_addr     = rd_addr_q;
  assign state       = state_q;
  assign load_words  = words_q;
  assign loops_done  = loops_q;
  assign replay_done = done_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_mem_replay_sched.sv
module tb_mem_replay_sched;
  localparam int AW = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, sw_rst, cal_done, start_load, start_replay, stop, wr_req, rd_req;
  logic [CW-1:0] replay_count;
  logic          wr_grant, rd_grant, replay_done, overflow;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [1:0]    state;
  logic [AW:0]   load_words;
  logic [CW-1:0] loops_done;

  int total = 0;
  int bad   = 0;

  // Reference model: phase, captured length, write pointer, replay index.
  bit [1:0] m_state = 0;
  int m_words = 0, m_wr = 0, m_idx = 0, m_loops = 0;
  bit m_ovf = 0, m_done = 0;

  always #5 clk = ~clk;

  mem_replay_sched #(.MEM_ADDR_WIDTH(AW), .MEM_ADDR_LOW(3'd0), .MEM_ADDR_HIGH(3'd7),
                     .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .sw_rst(sw_rst), .cal_done(cal_done),
    .start_load(start_load), .start_replay(start_replay), .stop(stop),
    .replay_count(replay_count), .wr_req(wr_req), .wr_grant(wr_grant), .wr_addr(wr_addr),
    .rd_req(rd_req), .rd_grant(rd_grant), .rd_addr(rd_addr), .state(state),
    .load_words(load_words), .loops_done(loops_done), .replay_done(replay_done),
    .overflow(overflow));

  function automatic logic [19:0] dut_vec();
    return {wr_grant, rd_grant, wr_addr, rd_addr, state, load_words, loops_done,
            replay_done, overflow};
  endfunction

  function automatic logic [19:0] exp_vec();
    bit wg, rg;
    wg = wr_req && cal_done && m_state == 1 && !m_ovf && !stop;
    rg = rd_req && cal_done && m_state == 2 && !stop;
    return {wg, rg, 3'(m_wr), 3'(m_idx), m_state, 4'(m_words), 4'(m_loops), m_done, m_ovf};
  endfunction

  // Advances the model by one clock using the inputs currently applied.
  function void model_clock();
    bit wg, rg;
    wg = wr_req && cal_done && m_state == 1 && !m_ovf && !stop;
    rg = rd_req && cal_done && m_state == 2 && !stop;
    m_done = 0;
    if (rst || sw_rst) begin
      m_state = 0; m_words = 0; m_wr = 0; m_idx = 0; m_loops = 0; m_ovf = 0;
      return;
    end
    case (m_state)
      0: if (!stop) begin
           if (start_load) begin
             m_words = 0; m_ovf = 0; m_loops = 0; m_wr = 0; m_state = 1;
           end else if (start_replay && m_words > 0) begin
             m_loops = 0; m_idx = 0; m_state = 2;
           end
         end
      1: begin
           if (wg) begin
             m_words++;
             if (m_wr == 7) m_ovf = 1; else m_wr++;
           end
           if (stop) m_state = 0;
           else if (start_replay) begin
             if (m_words > 0) begin m_state = 2; m_idx = 0; m_loops = 0; end
             else m_state = 0;
           end
         end
      2: begin
           if (stop) m_state = 0;
           else if (rg) begin
             m_idx++;
             if (m_idx == m_words) begin
               m_idx = 0;
               m_loops = (m_loops + 1) % 16;
               if (replay_count != 0 && m_loops == int'(replay_count)) begin
                 m_state = 0; m_done = 1;
               end
             end
           end
         end
      default: m_state = 0;
    endcase
  endfunction

  task automatic apply(input bit r, sr, cal, sl, sp, st, wq, rq);
    rst = r; sw_rst = sr; cal_done = cal; start_load = sl; start_replay = sp;
    stop = st; wr_req = wq; rd_req = rq;
    #1;
  endtask

  task automatic edge_();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic test_reset();
    replay_count = 0;
    apply(1, 0, 1, 0, 0, 0, 1, 1);
    edge_();
    total++;
    if (dut_vec() !== 20'h0) begin
      bad++; $display("FAIL reset_state got=%h want=%h", dut_vec(), 20'h0);
    end
    apply(0, 0, 1, 0, 0, 0, 1, 1);
    total++;
    if ({wr_grant, rd_grant} !== 2'b00) begin
      bad++; $display("FAIL reset_grants got=%b want=00", {wr_grant, rd_grant});
    end
    edge_();
  endtask

  task automatic test_empty_replay();
    apply(0, 0, 1, 0, 1, 0, 0, 1);
    total++;
    if (rd_grant !== 1'b0) begin bad++; $display("FAIL empty_rd_grant got=%b want=0", rd_grant); end
    edge_();
    apply(0, 0, 1, 0, 0, 0, 0, 1);
    total++;
    if ({state, rd_grant} !== 3'b000) begin
      bad++; $display("FAIL empty_state got=%b want=000", {state, rd_grant});
    end
    edge_();
  endtask

  task automatic test_basic_replay();
    replay_count = 2;
    apply(0, 0, 1, 1, 0, 0, 0, 0);
    edge_();
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 1, 0, 0, 0, 1, 0);
      total++;
      if ({wr_grant, wr_addr} !== {1'b1, 3'(i)}) begin
        bad++; $display("FAIL basic_wr[%0d] got=%b/%0d want=1/%0d", i, wr_grant, wr_addr, i);
      end
      edge_();
    end
    apply(0, 0, 1, 0, 1, 0, 0, 0);
    edge_();
    total++;
    if ({state, load_words} !== {2'd2, 4'd5}) begin
      bad++; $display("FAIL basic_enter got=%0d/%0d want=2/5", state, load_words);
    end
    for (int i = 0; i < 10; i++) begin
      apply(0, 0, 1, 0, 0, 0, 0, 1);
      total++;
      if ({rd_grant, rd_addr} !== {1'b1, 3'(i % 5)}) begin
        bad++; $display("FAIL basic_rd[%0d] got=%b/%0d want=1/%0d", i, rd_grant, rd_addr, i % 5);
      end
      edge_();
      total++;
      if (i < 9 && replay_done !== 1'b0) begin
        bad++; $display("FAIL basic_early_done[%0d] got=1 want=0", i);
      end else if (i == 9 && {replay_done, state, loops_done} !== {1'b1, 2'd0, 4'd2}) begin
        bad++; $display("FAIL basic_done got=%b/%0d/%0d want=1/0/2", replay_done, state, loops_done);
      end
    end
    apply(0, 0, 1, 0, 0, 0, 0, 0);
    edge_();
    total++;
    if (replay_done !== 1'b0) begin bad++; $display("FAIL basic_pulse_len got=1 want=0"); end
  endtask

  task automatic test_overflow();
    apply(0, 0, 1, 1, 0, 0, 0, 0);
    edge_();
    for (int i = 0; i < 10; i++) begin
      apply(0, 0, 1, 0, 0, 0, 1, 0);
      total++;
      if ({wr_grant, wr_addr} !== {i < 8, 3'(i < 8 ? i : 7)}) begin
        bad++; $display("FAIL ovf_wr[%0d] got=%b/%0d want=%0d/%0d", i, wr_grant, wr_addr,
                        i < 8, i < 8 ? i : 7);
      end
      edge_();
    end
    total++;
    if ({overflow, load_words} !== {1'b1, 4'd8}) begin
      bad++; $display("FAIL ovf_final got=%b/%0d want=1/8", overflow, load_words);
    end
    apply(0, 0, 1, 0, 0, 1, 0, 0);
    edge_();
  endtask

  task automatic test_cal_done();
    apply(0, 0, 1, 1, 0, 0, 0, 0);
    edge_();
    total++;
    if ({overflow, load_words, wr_addr} !== 8'h0) begin
      bad++; $display("FAIL cal_restart got=%b/%0d/%0d want=0/0/0", overflow, load_words, wr_addr);
    end
    for (int i = 0; i < 2; i++) begin apply(0, 0, 1, 0, 0, 0, 1, 0); edge_(); end
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, 0, 0, 1, 0);
      total++;
      if ({wr_grant, wr_addr} !== {1'b0, 3'd2}) begin
        bad++; $display("FAIL cal_hold[%0d] got=%b/%0d want=0/2", i, wr_grant, wr_addr);
      end
      edge_();
    end
    apply(0, 0, 1, 0, 0, 0, 1, 0);
    total++;
    if ({wr_grant, wr_addr} !== {1'b1, 3'd2}) begin
      bad++; $display("FAIL cal_resume got=%b/%0d want=1/2", wr_grant, wr_addr);
    end
    edge_();
    apply(0, 0, 1, 0, 0, 1, 1, 0);
    total++;
    if (wr_grant !== 1'b0) begin bad++; $display("FAIL load_stop_grant got=1 want=0"); end
    edge_();
    total++;
    if ({state, load_words} !== {2'd0, 4'd3}) begin
      bad++; $display("FAIL load_stop got=%0d/%0d want=0/3", state, load_words);
    end
  endtask

  task automatic test_infinite_stop();
    replay_count = 0;
    apply(0, 0, 1, 0, 1, 0, 0, 0);
    edge_();
    for (int i = 0; i < 7; i++) begin
      apply(0, 0, 1, 0, 0, 0, 0, 1);
      edge_();
      total++;
      if (replay_done !== 1'b0) begin bad++; $display("FAIL inf_done[%0d] got=1 want=0", i); end
    end
    apply(0, 0, 1, 0, 0, 1, 0, 1);
    total++;
    if (rd_grant !== 1'b0) begin bad++; $display("FAIL inf_stop_grant got=1 want=0"); end
    edge_();
    total++;
    if ({state, loops_done, replay_done, load_words} !== {2'd0, 4'd2, 1'b0, 4'd3}) begin
      bad++; $display("FAIL inf_stop got=%0d/%0d/%b/%0d want=0/2/0/3",
                      state, loops_done, replay_done, load_words);
    end
  endtask

  task automatic test_load_to_replay();
    replay_count = 1;
    apply(0, 0, 1, 1, 0, 0, 0, 0);
    edge_();
    apply(0, 0, 1, 0, 1, 0, 1, 0);
    edge_();
    total++;
    if ({state, load_words} !== {2'd2, 4'd1}) begin
      bad++; $display("FAIL same_cycle_replay got=%0d/%0d want=2/1", state, load_words);
    end
    apply(0, 0, 1, 0, 0, 0, 0, 1);
    edge_();
    total++;
    if ({replay_done, state, loops_done} !== {1'b1, 2'd0, 4'd1}) begin
      bad++; $display("FAIL single_pass got=%b/%0d/%0d want=1/0/1", replay_done, state, loops_done);
    end
  endtask

  task automatic test_sw_rst();
    replay_count = 0;
    apply(0, 0, 1, 1, 0, 0, 0, 0);
    edge_();
    for (int i = 0; i < 5; i++) begin apply(0, 0, 1, 0, 0, 0, 1, 0); edge_(); end
    apply(0, 0, 1, 0, 1, 0, 0, 0);
    edge_();
    for (int i = 0; i < 3; i++) begin apply(0, 0, 1, 0, 0, 0, 0, 1); edge_(); end
    total++;
    if ({state, rd_addr} !== {2'd2, 3'd3}) begin
      bad++; $display("FAIL swrst_pre got=%0d/%0d want=2/3", state, rd_addr);
    end
    apply(0, 1, 1, 0, 0, 0, 0, 1);
    edge_();
    apply(0, 0, 1, 0, 0, 0, 0, 0);
    total++;
    if (dut_vec() !== 20'h0) begin
      bad++; $display("FAIL swrst_clear got=%h want=%h", dut_vec(), 20'h0);
    end
    edge_();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      bit sl;
      if ($urandom_range(0, 29) == 0) replay_count = CW'($urandom_range(0, 3));
      sl = ($urandom_range(0, 19) == 0) && m_state != 1;
      apply($urandom_range(0, 149) == 0, $urandom_range(0, 149) == 0,
            $urandom_range(0, 7) != 0, sl, $urandom_range(0, 11) == 0,
            $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL rand_comb[%0d] got=%h want=%h", i, dut_vec(), exp_vec());
      end
      edge_();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL rand_reg[%0d] got=%h want=%h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_empty_replay();
    test_basic_replay();
    test_overflow();
    test_cal_done();
    test_infinite_stop();
    test_load_to_replay();
    test_sw_rst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
